// File: rtl/number_loader.sv
// number_loader: debounced load/sort front-end feeding four LFSR digits (0-9).
// Define NUMBER_LOADER_DEBOUNCE_EN to build the button debouncers.
module number_loader #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_load,
  input  logic       btn_sort,
  input  logic       sorting_done,
  output logic [3:0] random_num,
  output logic       load_num,
  output logic       sort_trigger,
  output logic       sort_rst,
  output logic [2:0] digits_loaded,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_GEN,
    S_LOAD,
    S_FULL,
    S_SORT,
    S_DONE
  } state_t;

  localparam logic [15:0] SEED =
    (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  logic [15:0] r_lfsr;
  logic [1:0]  r_sync1;
  logic [1:0]  r_sync2;
  logic [1:0]  w_lvl;
  logic [1:0]  r_lvl_d;
  logic [1:0]  r_press;
  logic        w_press_load;
  logic        w_press_sort;
  logic        w_accept;
  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_num;
  logic [2:0]  r_cnt;

  // free-running Galois LFSR, right shift
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lfsr <= SEED;
    end else begin
      r_lfsr <= {1'b0, r_lfsr[15:1]}
              ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {btn_sort, btn_load};
      r_sync2 <= r_sync1;
    end
  end

`ifdef NUMBER_LOADER_DEBOUNCE_EN
  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] r_db_cnt [2];
  logic [1:0]    r_db_lvl;

  // level changes only after DEBOUNCE_CYCLES differing samples in a row
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_db_cnt[0] <= '0;
      r_db_cnt[1] <= '0;
      r_db_lvl    <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_db_lvl[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == LAST) begin
          r_db_lvl[i] <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_lvl = r_db_lvl;
`else
  assign w_lvl = r_sync2;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lvl_d <= '0;
      r_press <= '0;
    end else begin
      r_lvl_d <= w_lvl;
      r_press <= w_lvl & ~r_lvl_d;
    end
  end

  assign w_press_load = r_press[0];
  assign w_press_sort = r_press[1];
  assign w_accept     = (r_lfsr[3:0] < 4'd10);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_press_load) w_next = S_CLR;
      S_CLR:  w_next = S_GEN;
      S_GEN:  if (w_accept) w_next = S_LOAD;
      S_LOAD: w_next = (r_cnt == 3'd3) ? S_FULL : S_GEN;
      S_FULL: begin
        if (w_press_load)      w_next = S_CLR;
        else if (w_press_sort) w_next = S_SORT;
      end
      S_SORT: if (sorting_done) w_next = S_DONE;
      S_DONE: if (w_press_load) w_next = S_CLR;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_num <= '0;
      r_cnt <= '0;
    end else begin
      if (r_state == S_GEN && w_accept) r_num <= r_lfsr[3:0];
      if (r_state == S_CLR)       r_cnt <= '0;
      else if (r_state == S_LOAD) r_cnt <= r_cnt + 3'd1;
    end
  end

  always_comb begin
    load_num     = 1'b0;
    sort_rst     = 1'b0;
    sort_trigger = 1'b0;
    busy         = 1'b0;
    unique case (1'b1)
      (r_state == S_CLR):  begin sort_rst     = 1'b1; busy = 1'b1; end
      (r_state == S_GEN):  begin busy         = 1'b1;              end
      (r_state == S_LOAD): begin load_num     = 1'b1; busy = 1'b1; end
      (r_state == S_SORT): begin sort_trigger = 1'b1; busy = 1'b1; end
      default: ;
    endcase
  end

  assign random_num    = r_num;
  assign digits_loaded = r_cnt;

endmodule

// File: tb/tb_number_loader.sv
// tb_number_loader: directed sequence checked against an LFSR/digit model.
// Latencies follow NUMBER_LOADER_DEBOUNCE_EN when the design is built with it.
module tb_number_loader;

`ifdef NUMBER_LOADER_DEBOUNCE_EN
  localparam int LAT = 3 + 8;
`else
  localparam int LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_load;
  logic       btn_sort;
  logic       sorting_done;
  logic [3:0] random_num;
  logic       load_num;
  logic       sort_trigger;
  logic       sort_rst;
  logic [2:0] digits_loaded;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] m_lfsr;

  number_loader #(
    .DEBOUNCE_CYCLES(8),
    .LFSR_SEED      (16'hACE1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_load     (btn_load),
    .btn_sort     (btn_sort),
    .sorting_done (sorting_done),
    .random_num   (random_num),
    .load_num     (load_num),
    .sort_trigger (sort_trigger),
    .sort_rst     (sort_rst),
    .digits_loaded(digits_loaded),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lf_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) m_lfsr <= 16'hACE1;
    else      m_lfsr <= lf_next(m_lfsr);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    btn_load = 1'b0;
    btn_sort = 1'b0;
    repeat (LAT + 3) tick();
  endtask

  // waits for sort_rst, predicts the four digits and their strobe cycles
  task automatic run_seq(input string tag);
    int j, ns, idx;
    int c;
    logic [15:0] x;
    int et[4];
    int ed[4];
    j = 0;
    do begin tick(); j++; end while (!sort_rst && j < LAT + 40);
    chk({tag, ".rst_lat"}, j, LAT + 1);
    if (!sort_rst) return;
    x = lf_next(m_lfsr);
    c = 1;
    for (int i = 0; i < 4; i++) begin
      while (x[3:0] >= 4'd10) begin
        x = lf_next(x);
        c++;
      end
      ed[i] = int'(x[3:0]);
      et[i] = c + 1;
      x = lf_next(lf_next(x));
      c += 2;
    end
    ns = 0;
    for (int k = 1; k <= et[3] + 6; k++) begin
      tick();
      idx = -1;
      for (int i = 0; i < 4; i++) if (et[i] == k) idx = i;
      chk({tag, ".load_num"}, load_num, (idx >= 0) ? 1 : 0);
      chk({tag, ".sort_rst"}, sort_rst, 0);
      chk({tag, ".sort_trig"}, sort_trigger, 0);
      chk({tag, ".busy"}, busy, (k <= et[3]) ? 1 : 0);
      if (load_num) ns++;
      if (idx >= 0) begin
        chk({tag, ".digit"}, random_num, ed[idx]);
        chk({tag, ".cnt_pre"}, digits_loaded, idx);
      end
      for (int i = 0; i < 4; i++)
        if (et[i] + 1 == k) chk({tag, ".cnt"}, digits_loaded, i + 1);
    end
    chk({tag, ".strobes"}, ns, 4);
    chk({tag, ".final_cnt"}, digits_loaded, 4);
  endtask

  task automatic sort_run(input string tag, input int done_at,
                          input int want_hi);
    int j, hi;
    btn_sort = 1'b1;
    j = 0;
    do begin tick(); j++; end while (!sort_trigger && j < LAT + 40);
    chk({tag, ".lat"}, j, LAT + 1);
    btn_sort = 1'b0;
    hi = sort_trigger ? 1 : 0;
    for (int k = 1; k <= 30 && hi > 0; k++) begin
      tick();
      if (!sort_trigger) break;
      hi++;
      if (k == done_at) sorting_done = 1'b1;
    end
    chk({tag, ".hi"}, hi, want_hi);
    chk({tag, ".busy"}, busy, 0);
    sorting_done = 1'b0;
    settle();
  endtask

  initial begin
    int j, hits;
    rst          = 1'b0;
    btn_load     = 1'b0;
    btn_sort     = 1'b0;
    sorting_done = 1'b0;
    #22;
    rst = 1'b1;

    for (int k = 0; k < 20; k++) begin
      tick();
      chk("idle.outs", {random_num, load_num, sort_trigger, sort_rst,
                        digits_loaded, busy}, 0);
      chk("idle.lfsr", dut.r_lfsr, m_lfsr);
    end

    btn_load = 1'b1;
    run_seq("seqA");
    settle();

    sort_run("sort6", 5, 6);

    btn_load = 1'b1;
    run_seq("seqB");
    settle();

    btn_load = 1'b1;
    btn_sort = 1'b1;
    run_seq("both");
    settle();

    sorting_done = 1'b1;
    sort_run("stuck", 0, 1);

    btn_load = 1'b1;
    j = 0;
    do begin tick(); j++; end while (!sort_rst && j < LAT + 40);
    chk("rmid.clr", sort_rst, 1);
    j = 0;
    do begin tick(); j++; end while (!load_num && j < 40);
    chk("rmid.strobe1", load_num, 1);
    tick();
    chk("rmid.cnt1", digits_loaded, 1);
    rst = 1'b0;
    #1;
    chk("rmid.outs", {random_num, load_num, sort_trigger, sort_rst,
                      digits_loaded, busy}, 0);
    btn_load = 1'b0;
    #2;
    rst = 1'b1;
    for (int k = 0; k < LAT + 3; k++) begin
      tick();
      chk("rmid.idle", {sort_rst, busy}, 0);
    end
    btn_load = 1'b1;
    run_seq("reload");
    settle();

`ifdef NUMBER_LOADER_DEBOUNCE_EN
    for (int b = 0; b < 3; b++) begin
      btn_load = 1'b1;
      repeat (4) tick();
      btn_load = 1'b0;
      repeat (4) tick();
    end
    btn_load = 1'b1;
    run_seq("bounce");
    hits = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (sort_rst) hits++;
    end
    chk("bounce.once", hits, 0);
    settle();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
